ecc_store_unit: RTL and testbench
=================================

Name: ecc_store_unit

Overview:
- Store-side counterpart of the ECC-corrected load path. Accepts store requests from the memory stage, SECDED-encodes the data and writes 39-bit codewords into data memory.
- Byte and halfword stores use read-modify-write: read the codeword, correct it, merge the new lanes, re-encode, write back.
- Stalls the pipeline through st_ready while a store is in flight.

Parameters:
- ADDR_WIDTH, 10, word-address width of the data memory.
- DATA_WIDTH, 32, data bits per word; fixed at 32 for the (39,32) code.
- CODE_WIDTH, 39, codeword width: 32 data bits, 6 Hamming check bits, 1 overall parity bit.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  unit can accept a request this cycle.
- st_addr  in  32  byte address.
- st_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- st_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  word address, equal to st_addr[ADDR_WIDTH+1:2].
- mem_wdata  out  CODE_WIDTH  encoded write codeword.
- mem_rdata  in  CODE_WIDTH  read codeword, valid 1 cycle after a read (mem_en=1, mem_we=0).
- ecc_corr  out  1  1-cycle pulse: a single-bit error was corrected during an RMW read.
- ecc_uncorr  out  1  1-cycle pulse: double-bit error detected; the store is aborted.
- st_misaligned  out  1  1-cycle pulse: the request was dropped as misaligned or illegal.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0 except st_ready, which goes to 1.
  - Internal registers are cleared.
- Reset mid-operation: any in-flight store is abandoned, and no write is issued on the cycle after reset is applied.
- Codeword layout:
  - [31:0] data.
  - [37:32] check bits c0..c5. Data bits map in ascending order onto the non-power-of-two Hamming positions 3,5,6,7,9,...,38. c_i is the XOR of the data bits whose position has bit i set.
  - [38] XOR of bits [37:0].
- Decode (syndrome s = recomputed check bits XOR stored check bits; p = XOR over all 39 bits):
  - s=0, p=0: clean.
  - s!=0, p=1: flip the bit at position s; ecc_corr=1.
  - s=0, p=1: parity-bit error, data is good; ecc_corr=1.
  - s!=0, p=0: uncorrectable; ecc_uncorr=1.
- Handshake:
  - A request is accepted on a cycle with st_valid=1 and st_ready=1.
  - st_ready=0 from the cycle after acceptance until the unit returns to IDLE.
  - The producer holds the request stable while st_ready=0.
  - The accepted request (address, data, size) is captured in registers.
- Alignment:
  - Half requires st_addr[0]=0. Word requires st_addr[1:0]=0.
  - A misaligned request, or st_size=11, is consumed: st_misaligned pulses on the cycle after acceptance, the FSM stays in IDLE and no memory access is made.
- FSM for a word store (latency 1):
  - IDLE, on acceptance, goes to WRITE.
  - WRITE: mem_en=1, mem_we=1, mem_wdata = encode(data), st_ready=0. Then go to IDLE.
- FSM for byte/half stores (latency 3):
  - IDLE goes to READ.
  - READ: mem_en=1, mem_we=0. Then go to MERGE.
  - MERGE: sample mem_rdata, decode and correct it, merge the lanes, register encode(merged). Then go to WRITE.
  - WRITE as above, then go to IDLE.
  - ecc_corr and ecc_uncorr pulse during MERGE.
  - If uncorrectable: skip WRITE, go to IDLE, and leave memory unmodified.
- Merge lanes:
  - Byte lane = st_addr[1:0], replacing bits [8*lane+7 : 8*lane].
  - Half lane = st_addr[1], replacing bits [16*lane+15 : 16*lane].
- mem_addr is held constant from READ through WRITE.
- Back-to-back: a new request can be accepted on the first IDLE cycle after WRITE, so the best-case word throughput is 1 store per 2 cycles.
- When not in READ or WRITE, mem_en and mem_we are 0.

Decomposition:
- Shared package ecc_pkg holds:
  - Width constants.
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum: IDLE, READ, MERGE, WRITE.
  - Functions secded_encode and secded_syndrome, also used by the load path.
- One natural sub-module: secded_codec.
  - Combinational.
  - Encodes a 32-bit word to 39 bits.
  - Decodes 39 bits to corrected data plus corr/uncorr flags.

Test Plan:
- Word store, st_addr=0x40, data 0xDEADBEEF → one cycle later: mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=encode(0xDEADBEEF); st_ready=0 for exactly 1 cycle.
- Memory[0x10]=encode(0x11223344); byte store 0xAB to 0x41 → READ, MERGE, WRITE over 3 cycles; mem_wdata=encode(0x1122AB44).
- Same setup, but mem_rdata has data bit 5 flipped; half store 0xBEEF to 0x42 → ecc_corr pulses; written word is encode(0xBEEF3344).
- mem_rdata has bits 3 and 17 flipped during a byte store → ecc_uncorr pulses; no cycle with mem_we=1; back in IDLE after 2 cycles.
- Half store to 0x43, then word store to 0x46, then st_size=11 → st_misaligned pulses for each; no mem_en.
- Byte store accepted, rst=0 during READ → next cycle all outputs 0 and st_ready=1; no write ever issued.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED (39,32) definitions for the ECC load and store paths.
// Hamming positions 1..38 carry check bits at powers of two and data elsewhere.
package ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 6;
  localparam int CODE_W = 39;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    MERGE,
    WRITE
  } state_e;

  // Hamming position of data bit idx: the idx-th non-power-of-two position from 3 up.
  function automatic logic [CHK_W-1:0] data_pos(input int unsigned idx);
    int unsigned n;
    logic [CHK_W-1:0] pos;
    n   = 0;
    pos = '0;
    for (int unsigned p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = CHK_W'(p);
        n++;
      end
    end
    return pos;
  endfunction

  function automatic logic [CHK_W-1:0] secded_check(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    logic [CHK_W-1:0] pos;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pos = data_pos(i);
      for (int k = 0; k < CHK_W; k++) begin
        if (pos[k]) c[k] = c[k] ^ d[i];
      end
    end
    return c;
  endfunction

  function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = secded_check(d);
    return {^{c, d}, c, d};
  endfunction

  function automatic logic [CHK_W-1:0] secded_syndrome(input logic [CODE_W-1:0] cw);
    return secded_check(cw[DATA_W-1:0]) ^ cw[DATA_W+CHK_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED (39,32) encoder plus single-error-correcting decoder.
module secded_codec
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code,
  input  logic [CODE_W-1:0] i_code,
  output logic [DATA_W-1:0] o_data,
  output logic              o_corr,
  output logic              o_uncorr
);

  logic [CHK_W-1:0] w_syn;
  logic             w_par;

  assign o_code = secded_encode(i_data);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_syn    = secded_syndrome(i_code);
    w_par    = ^i_code;
    o_data   = i_code[DATA_W-1:0];
    o_corr   = 1'b0;
    o_uncorr = 1'b0;
    if (w_syn != '0) begin
      // A syndrome beyond position 38 points at no real bit, so it cannot be a single error.
      if (!w_par || w_syn > CHK_W'(38)) begin
        o_uncorr = 1'b1;
      end else begin
        o_corr = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
          if (data_pos(i) == w_syn) o_data[i] = ~o_data[i];
        end
      end
    end else if (w_par) begin
      o_corr = 1'b1;
    end
  end

endmodule

// File: rtl/ecc_store_unit.sv
// Store path into ECC-protected data memory: word stores write directly,
// byte/half stores do read-correct-merge-encode-write.
module ecc_store_unit
  import ecc_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 39
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [31:0]           st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            st_size,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CODE_WIDTH-1:0] mem_wdata,
  input  logic [CODE_WIDTH-1:0] mem_rdata,
  output logic                  ecc_corr,
  output logic                  ecc_uncorr,
  output logic                  st_misaligned
);

  state_e                r_state;
  state_e                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_lane;
  size_e                 r_size;
  logic [DATA_W-1:0]     r_data;
  logic [CODE_W-1:0]     r_code;
  logic                  r_misaligned;

  size_e                 w_size;
  logic                  w_accept;
  logic                  w_bad;
  logic [DATA_W-1:0]     w_enc_in;
  logic [CODE_W-1:0]     w_enc;
  logic [DATA_W-1:0]     w_dec_data;
  logic                  w_corr;
  logic                  w_uncorr;
  logic [DATA_W-1:0]     w_merged;
  logic                  w_unused_addr;

  assign w_unused_addr = ^st_addr[31:ADDR_WIDTH+2];

  assign w_size   = size_e'(st_size);
  assign w_accept = st_valid && st_ready;
  assign w_bad    = (w_size == SZ_BAD)
                 || (w_size == SZ_HALF && st_addr[0])
                 || (w_size == SZ_WORD && st_addr[1:0] != 2'b00);

  // One encoder serves both the direct word path and the RMW re-encode.
  assign w_enc_in = (r_state == MERGE) ? w_merged : st_data;

  secded_codec u_codec (
    .i_data   (w_enc_in),
    .o_code   (w_enc),
    .i_code   (mem_rdata),
    .o_data   (w_dec_data),
    .o_corr   (w_corr),
    .o_uncorr (w_uncorr)
  );

  always_comb begin
    w_merged = w_dec_data;
    case (r_size)
      SZ_BYTE: w_merged[{r_lane, 3'b000} +: 8]     = r_data[7:0];
      SZ_HALF: w_merged[{r_lane[1], 4'b0000} +: 16] = r_data[15:0];
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_lane       <= '0;
      r_size       <= SZ_BYTE;
      r_data       <= '0;
      r_code       <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_misaligned <= w_accept && w_bad;
      if (w_accept) begin
        r_addr <= st_addr[ADDR_WIDTH+1:2];
        r_lane <= st_addr[1:0];
        r_size <= w_size;
        r_data <= st_data;
      end
      if ((w_accept && !w_bad) || r_state == MERGE) r_code <= w_enc;
    end
  end

  always_comb begin
    w_next     = r_state;
    st_ready   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    ecc_corr   = 1'b0;
    ecc_uncorr = 1'b0;
    case (r_state)
      IDLE: begin
        st_ready = 1'b1;
        if (w_accept && !w_bad) w_next = (w_size == SZ_WORD) ? WRITE : READ;
      end
      READ: begin
        mem_en = 1'b1;
        w_next = MERGE;
      end
      MERGE: begin
        ecc_corr   = w_corr;
        ecc_uncorr = w_uncorr;
        w_next     = w_uncorr ? IDLE : WRITE;
      end
      WRITE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_addr      = r_addr;
  assign mem_wdata     = r_code;
  assign st_misaligned = r_misaligned;

endmodule

// File: tb/tb_ecc_store_unit.sv
// Directed bench for ecc_store_unit with a behavioural codeword memory.
module tb_ecc_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [38:0] mem_wdata;
  logic [38:0] mem_rdata;
  logic        ecc_corr;
  logic        ecc_uncorr;
  logic        st_misaligned;

  logic [38:0] tb_mem [0:1023];
  logic [38:0] rd_q;
  logic [38:0] err_mask;
  int          write_cnt;
  int          acc_cnt;
  int          n_vec;
  int          n_err;
  int          w0;
  int          a0;

  always #5 clk = ~clk;

  ecc_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .ecc_corr     (ecc_corr),
    .ecc_uncorr   (ecc_uncorr),
    .st_misaligned(st_misaligned)
  );

  assign mem_rdata = rd_q ^ err_mask;

  always @(posedge clk) begin
    if (mem_en) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_we) begin
        tb_mem[mem_addr] <= mem_wdata;
        write_cnt        <= write_cnt + 1;
      end else begin
        rd_q <= tb_mem[mem_addr];
      end
    end
  end

  // Reference Hamming encoder built from an explicit position array.
  function automatic logic [38:0] ref_encode(input logic [31:0] d);
    logic [38:1] h;
    logic [5:0]  c;
    int          k;
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) == 0) h[pos] = 1'b0;
      else begin
        h[pos] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      c[i] = 1'b0;
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> i) & 1) == 1) c[i] = c[i] ^ h[pos];
    end
    return {^{c, d}, c, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns in the cycle after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    step();
    st_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, 64'(st_ready), 64'd1);
    check({tag, ".en"},    64'(mem_en),   64'd0);
    check({tag, ".we"},    64'(mem_we),   64'd0);
    check({tag, ".flags"}, 64'({ecc_corr, ecc_uncorr, st_misaligned}), 64'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; write_cnt = 0; acc_cnt = 0;
    err_mask = '0; rd_q = '0;
    for (int i = 0; i < 1024; i++) tb_mem[i] = '0;
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b10;
    step(); step();
    check_idle("reset");
    check("reset.addr",  64'(mem_addr),  64'd0);
    check("reset.wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b1;
    step();

    // Word store: one WRITE cycle, then ready again.
    send(32'h40, 32'hDEADBEEF, 2'b10);
    check("word.en",    64'({mem_en, mem_we}), 64'd3);
    check("word.addr",  64'(mem_addr),  64'h10);
    check("word.wdata", 64'(mem_wdata), 64'(ref_encode(32'hDEADBEEF)));
    check("word.busy",  64'(st_ready),  64'd0);
    step();
    check_idle("word.done");
    check("word.mem",   64'(tb_mem[10'h10]), 64'(ref_encode(32'hDEADBEEF)));

    // Back-to-back word store with a hand-encoded codeword.
    send(32'h44, 32'h1, 2'b10);
    check("word1.wdata", 64'(mem_wdata), 64'h43_0000_0001);
    step();

    // Byte store RMW into lane 1.
    tb_mem[10'h10] = ref_encode(32'h11223344);
    send(32'h41, 32'hAB, 2'b00);
    check("byte.read", 64'({mem_en, mem_we, st_ready}), 64'b100);
    check("byte.raddr", 64'(mem_addr), 64'h10);
    step();
    check("byte.merge", 64'({mem_en, ecc_corr, ecc_uncorr}), 64'd0);
    step();
    check("byte.write", 64'({mem_en, mem_we}), 64'd3);
    check("byte.wdata", 64'(mem_wdata), 64'(ref_encode(32'h1122AB44)));
    step();
    check_idle("byte.done");

    // Half store with a corrected single-bit read error.
    tb_mem[10'h10] = ref_encode(32'h11223344);
    err_mask = 39'h20;
    send(32'h42, 32'hBEEF, 2'b01);
    step();
    check("half.corr", 64'({ecc_corr, ecc_uncorr}), 64'b10);
    step();
    check("half.wdata", 64'(mem_wdata), 64'(ref_encode(32'hBEEF3344)));
    check("half.corr_off", 64'(ecc_corr), 64'd0);
    err_mask = '0;
    step();

    // Byte store into lane 3 of an all-zero word.
    send(32'h1F, 32'hCD, 2'b00);
    step(); step();
    check("lane3.wdata", 64'(mem_wdata), 64'(ref_encode(32'hCD000000)));
    step();

    // Double-bit read error aborts the store.
    tb_mem[10'h10] = ref_encode(32'h11223344);
    err_mask = (39'h1 << 3) | (39'h1 << 17);
    w0 = write_cnt;
    send(32'h40, 32'h55, 2'b00);
    step();
    check("dbl.uncorr", 64'({ecc_corr, ecc_uncorr}), 64'b01);
    step();
    check_idle("dbl.idle");
    err_mask = '0;
    step();
    check("dbl.nowrite", 64'(write_cnt), 64'(w0));
    check("dbl.mem", 64'(tb_mem[10'h10]), 64'(ref_encode(32'h11223344)));

    // Misaligned and illegal requests are dropped.
    a0 = acc_cnt;
    send(32'h43, 32'h1234, 2'b01);
    check("mis.half", 64'({st_misaligned, st_ready, mem_en}), 64'b110);
    send(32'h46, 32'h5678, 2'b10);
    check("mis.word", 64'({st_misaligned, st_ready, mem_en}), 64'b110);
    send(32'h40, 32'h9ABC, 2'b11);
    check("mis.ill",  64'({st_misaligned, st_ready, mem_en}), 64'b110);
    step();
    check("mis.pulse_off", 64'(st_misaligned), 64'd0);
    check("mis.noacc", 64'(acc_cnt), 64'(a0));

    // Reset during READ abandons the store.
    w0 = write_cnt;
    send(32'h41, 32'hEE, 2'b00);
    check("rst.read", 64'(mem_en), 64'd1);
    rst = 1'b0;
    step();
    check_idle("rst.mid");
    check("rst.wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b1;
    repeat (4) step();
    check("rst.nowrite", 64'(write_cnt), 64'(w0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
